// File: rtl/vga_timing_decoder.sv
// Recovers pixel_x/pixel_y (generator coordinates delayed 2 clocks) from hsync/vsync; locks after LOCK_FRAMES matched frames.
// Define VGA_DEC_MEASURE_EN to add line_len/frame_lines measurement; otherwise both read 0.
module vga_timing_decoder #(
   parameter int WIDTH       = 800,
   parameter int HEIGHT      = 525,
   parameter int HSYNC_START = 663,
   parameter int VSYNC_START = 490,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       clk_25m,
   input  logic       rst_n,
   input  logic       hsync,
   input  logic       vsync,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       valid,
   output logic       locked,
   output logic       frame_start,
   output logic       timing_err,
   output logic [9:0] line_len,
   output logic [9:0] frame_lines
);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   localparam logic [9:0] X_LAST    = 10'(WIDTH - 1);
   localparam logic [9:0] Y_LAST    = 10'(HEIGHT - 1);
   localparam logic [9:0] H_LOAD    = 10'(HSYNC_START);
   localparam logic [9:0] H_PRE     = 10'(HSYNC_START - 1);
   localparam logic [9:0] V_LOAD    = 10'(VSYNC_START);
   localparam logic [9:0] V_PRE     = 10'(VSYNC_START - 1);
   localparam logic [9:0] X_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0] Y_ACT     = 10'(V_ACTIVE);
   localparam logic [7:0] GOOD_LOCK = 8'(LOCK_FRAMES);

   logic       hs1_q, hs2_q, vs1_q, vs2_q;
   state_t     state_q, state_d;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic [7:0] good_q, good_d;
   logic       valid_q, valid_d, locked_q, locked_d;
   logic       frame_start_q, frame_start_d, timing_err_q, timing_err_d;
   logic       h_edge, v_edge, h_edge_nx, v_edge_nx, err;

   // Edge mismatch rules; a missing edge only counts against us once locked.
   function automatic logic sync_err(input state_t st, input logic [9:0] x, input logic [9:0] y,
                                     input logic he, input logic ve);
      logic h_exp, v_exp;
      h_exp = (x == H_PRE);
      v_exp = (x == X_LAST) && (y == V_PRE);
      case (st)
         ACQUIRE: sync_err = (he && !h_exp) || (ve && !v_exp);
         LOCKED:  sync_err = (he != h_exp) || (ve != v_exp);
         default: sync_err = 1'b0;
      endcase
   endfunction

   always_comb begin
      h_edge    = ~hs1_q & hs2_q;
      v_edge    = ~vs1_q & vs2_q;
      h_edge_nx = ~hsync & hs1_q;
      v_edge_nx = ~vsync & vs1_q;
      err       = sync_err(state_q, x_q, y_q, h_edge, v_edge);

      x_d = (x_q == X_LAST) ? 10'd0 : x_q + 10'd1;
      y_d = y_q;
      if (x_q == X_LAST) begin
         y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
      end
      if (h_edge) begin
         x_d = H_LOAD;
      end
      if (v_edge) begin
         y_d = V_LOAD;
      end

      state_d = state_q;
      good_d  = good_q;
      case (state_q)
         SEARCH: begin
            if (v_edge) begin
               state_d = ACQUIRE;
               good_d  = 8'd0;
            end
         end
         ACQUIRE: begin
            if (err) begin
               state_d = SEARCH;
               good_d  = 8'd0;
            end else if (v_edge) begin
               good_d = good_q + 8'd1;
               if (good_d == GOOD_LOCK) begin
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (err) begin
               state_d = SEARCH;
               good_d  = 8'd0;
            end
         end
         default: begin
            state_d = SEARCH;
            good_d  = 8'd0;
         end
      endcase

      // Outputs are registered from next-state values so they line up with pixel_x/pixel_y.
      locked_d      = (state_d == LOCKED);
      valid_d       = locked_d && (x_d < X_ACT) && (y_d < Y_ACT);
      frame_start_d = locked_d && (x_d == 10'd0) && (y_d == 10'd0);
      timing_err_d  = sync_err(state_d, x_d, y_d, h_edge_nx, v_edge_nx);
   end

   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         hs1_q         <= 1'b1;
         hs2_q         <= 1'b1;
         vs1_q         <= 1'b1;
         vs2_q         <= 1'b1;
         state_q       <= SEARCH;
         x_q           <= 10'd0;
         y_q           <= 10'd0;
         good_q        <= 8'd0;
         valid_q       <= 1'b0;
         locked_q      <= 1'b0;
         frame_start_q <= 1'b0;
         timing_err_q  <= 1'b0;
      end else begin
         hs1_q         <= hsync;
         hs2_q         <= hs1_q;
         vs1_q         <= vsync;
         vs2_q         <= vs1_q;
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         good_q        <= good_d;
         valid_q       <= valid_d;
         locked_q      <= locked_d;
         frame_start_q <= frame_start_d;
         timing_err_q  <= timing_err_d;
      end
   end

   assign pixel_x     = x_q;
   assign pixel_y     = y_q;
   assign valid       = valid_q;
   assign locked      = locked_q;
   assign frame_start = frame_start_q;
   assign timing_err  = timing_err_q;

`ifdef VGA_DEC_MEASURE_EN
   logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic [9:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;

   // Counters saturate so a dead sync input cannot wrap into a plausible value.
   always_comb begin
      hcnt_d        = (hcnt_q == 10'h3ff) ? hcnt_q : hcnt_q + 10'd1;
      line_len_d    = line_len_q;
      vcnt_d        = vcnt_q;
      frame_lines_d = frame_lines_q;
      if (h_edge) begin
         hcnt_d     = 10'd0;
         line_len_d = hcnt_q;
      end
      if (v_edge) begin
         frame_lines_d = (vcnt_q == 10'd0) ? 10'd0 : vcnt_q - 10'd1;
         vcnt_d        = 10'd0;
      end
      if (h_edge && vcnt_d != 10'h3ff) begin
         vcnt_d = vcnt_d + 10'd1;
      end
   end

   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q        <= 10'd0;
         vcnt_q        <= 10'd0;
         line_len_q    <= 10'd0;
         frame_lines_q <= 10'd0;
      end else begin
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
      end
   end

   assign line_len    = line_len_q;
   assign frame_lines = frame_lines_q;
`else
   assign line_len    = 10'd0;
   assign frame_lines = 10'd0;
`endif

endmodule

// File: doc/vga_timing_decoder.md
VGA_TIMING_DECODER -- requirements
Module: vga_timing_decoder

Interface
REQ-001 Parameter WIDTH, 800, total clocks per line.
REQ-002 Parameter HEIGHT, 525, total lines per frame.
REQ-003 Parameter HSYNC_START, 663, generator x of first hsync-low sample.
REQ-004 Parameter VSYNC_START, 490, generator y of first vsync-low line.
REQ-005 Parameter H_ACTIVE, 640 / V_ACTIVE, 480, visible area size.
REQ-006 Parameter LOCK_FRAMES, 2, consecutive matched frames needed to lock.
REQ-007 clk_25m  input  1  pixel clock, all logic on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 hsync  input  1  active-low horizontal sync from the sync generator.
REQ-010 vsync  input  1  active-low vertical sync from the sync generator.
REQ-011 pixel_x  output  10  recovered column, registered.
REQ-012 pixel_y  output  10  recovered row, registered.
REQ-013 valid  output  1  locked and pixel_x<H_ACTIVE and pixel_y<V_ACTIVE.
REQ-014 locked  output  1  high in LOCKED state.
REQ-015 frame_start  output  1  one-cycle pulse, locked and (pixel_x,pixel_y)=(0,0).
REQ-016 timing_err  output  1  one-cycle pulse on any sync mismatch while ACQUIRE or LOCKED.
REQ-017 line_len  output  10  measured clocks between hsync falling edges, minus 1.
REQ-018 frame_lines  output  10  measured hsync edges between vsync falling edges, minus 1.

Function
REQ-019 hsync/vsync SHALL each pass two flops (s1, s2); falling edge = s1 low and s2 high.
REQ-020 x counter SHALL count 0..WIDTH-1 and wrap; y SHALL increment on x wrap, 0..HEIGHT-1, wrap.
REQ-021 On hsync edge x SHALL load HSYNC_START next cycle; match iff x==HSYNC_START-1 at edge cycle.
REQ-022 On vsync edge y SHALL load VSYNC_START (priority over wrap increment); match iff x==WIDTH-1 and y==VSYNC_START-1.
REQ-023 Once locked, pixel_x/pixel_y SHALL equal generator coordinates delayed exactly 2 cycles.
REQ-024 FSM states SEARCH, ACQUIRE, LOCKED; reset state SEARCH.
REQ-025 SEARCH: counters resync on every edge, no error reporting; first vsync edge -> ACQUIRE, good count=0.
REQ-026 ACQUIRE: each matched vsync edge increments good count; count reaching LOCK_FRAMES -> LOCKED.
REQ-027 ACQUIRE: any hsync or vsync mismatch -> timing_err pulse, SEARCH.
REQ-028 LOCKED: mismatched edge, or no hsync edge when x==HSYNC_START-1, or no vsync edge when x==WIDTH-1 and y==VSYNC_START-1 -> timing_err pulse, SEARCH, locked low next cycle.
REQ-029 Simultaneous hsync and vsync errors SHALL yield a single timing_err pulse.
REQ-030 Counters SHALL keep resyncing on edges in every state; valid and frame_start forced low unless LOCKED.

Reset
REQ-031 rst_n low SHALL immediately clear pixel_x, pixel_y, counters, good count, valid, locked, frame_start, timing_err, line_len, frame_lines to 0.
REQ-032 Sync flops SHALL reset to 1 (idle high) so no false edge follows reset.
REQ-033 Reset mid-frame SHALL return to SEARCH; relock requires full SEARCH/ACQUIRE sequence.

Configuration
REQ-034 Macro VGA_DEC_MEASURE_EN defined: line_len and frame_lines update on every hsync/vsync edge respectively, in all states.
REQ-035 Macro undefined: measurement counters absent, line_len and frame_lines tied to 0; all other behaviour identical.

Verification
REQ-036 Reset, then nominal 800x525 generator -> locked rises 1 cycle after 3rd vsync edge detect; timing_err never pulses.
REQ-037 Locked, generator at x=0,y=0 -> frame_start pulses 2 cycles later with pixel_x=0, pixel_y=0; valid low at pixel_x=640.
REQ-038 Locked, one hsync pulse suppressed -> timing_err single pulse at x==662, locked low next cycle, relock after 3 vsync edges.
REQ-039 Locked, hsync falls 5 clocks early on one line -> timing_err, SEARCH; pixel_x reloads 663.
REQ-040 VGA_DEC_MEASURE_EN defined, nominal timing -> line_len=799, frame_lines=524; undefined -> both 0.
REQ-041 rst_n low for 1 cycle at pixel (300,200) while locked -> all outputs 0 asynchronously, no timing_err, locked reacquired normally.
